l2_wb_scheduler: RTL and testbench

//  Sits between the unified L2 and physical memory. Schedules the single pmem port

---
 rtl/l2_wb_pkg.sv | 22 ++
 rtl/wb_buffer_cam.sv | 77 +++++++
 rtl/l2_wb_scheduler.sv | 168 ++++++++++++++++
 tb/tb_l2_wb_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_wb_pkg.sv
// Shared types and widths for the L2 write-back scheduler and its buffer.
package l2_wb_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } wb_entry_t;

endpackage

// File: rtl/wb_buffer_cam.sv
// Circular write-back buffer with a parallel tag compare for forwarding and coalescing.
module wb_buffer_cam
  import l2_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [TAG_W-1:0]           lookup_tag_i,
  input  logic [LINE_W-1:0]          wline_i,
  input  logic                       enq_i,
  input  logic                       coal_i,
  input  logic [$clog2(DEPTH)-1:0]   coal_idx_i,
  input  logic                       pop_i,
  output logic                       hit_o,
  output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
  output logic [LINE_W-1:0]          hit_line_o,
  output logic [TAG_W-1:0]           head_tag_o,
  output logic [LINE_W-1:0]          head_line_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        ent_q [DEPTH];
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  // Tags are unique across valid entries, so at most one iteration fires.
  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    hit_line_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_q[i].valid && (ent_q[i].tag == lookup_tag_i)) begin
        hit_o      = 1'b1;
        hit_idx_o  = IDX_W'(i);
        hit_line_o = ent_q[i].line;
      end
    end
  end

  assign head_tag_o  = ent_q[head_q].tag;
  assign head_line_o = ent_q[head_q].line;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);

  // Enqueue and pop never coincide: up side and pmem side complete in different states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_i) begin
        ent_q[tail_q] <= wb_entry_t'{valid: 1'b1, tag: lookup_tag_i, line: wline_i};
        tail_q        <= tail_q + IDX_W'(1);
        count_q       <= count_q + CNT_W'(1);
      end
      if (coal_i) begin
        ent_q[coal_idx_i].line <= wline_i;
      end
      if (pop_i) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + IDX_W'(1);
        count_q             <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/l2_wb_scheduler.sv
// Arbitrates the single pmem port between L2 line reads and buffered L2 evictions;
// reads bypass queued writes and hit buffered lines directly.
module l2_wb_scheduler
  import l2_wb_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned DRAIN_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [LINE_W-1:0] up_wdata,
  output logic              up_resp,
  output logic [LINE_W-1:0] up_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              wb_empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned IC_W  = $clog2(DRAIN_DELAY + 1);

  state_e            state_q;
  logic [IC_W-1:0]   idle_cnt_q;
  logic              up_resp_q;
  logic [LINE_W-1:0] up_rdata_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic [LINE_W-1:0] hit_line;
  logic [TAG_W-1:0]  head_tag;
  logic [LINE_W-1:0] head_line;
  logic              full;
  logic              empty;
  logic              enq_c;
  logic              coal_c;
  logic              pop_c;
  logic              unused_offset;

  assign req_tag       = up_addr[ADDR_W-1:OFFSET_W];
  assign unused_offset = ^up_addr[OFFSET_W-1:0];

  wb_buffer_cam #(.DEPTH(DEPTH)) u_cam (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_tag_i (req_tag),
    .wline_i      (up_wdata),
    .enq_i        (enq_c),
    .coal_i       (coal_c),
    .coal_idx_i   (hit_idx),
    .pop_i        (pop_c),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .hit_line_o   (hit_line),
    .head_tag_o   (head_tag),
    .head_line_o  (head_line),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Buffer write strobes; they fire on the same edge the FSM leaves IDLE or DRAIN.
  always_comb begin
    enq_c  = 1'b0;
    coal_c = 1'b0;
    pop_c  = 1'b0;
    if ((state_q == IDLE) && !up_read && up_write) begin
      coal_c = hit;
      enq_c  = !hit && !full;
    end
    if ((state_q == DRAIN) && pmem_resp) begin
      pop_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idle_cnt_q     <= '0;
      up_resp_q      <= 1'b0;
      up_rdata_q     <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      up_resp_q <= 1'b0;
      if (state_q != IDLE) begin
        idle_cnt_q <= '0;
      end
      unique case (state_q)
        IDLE: begin
          if (up_read) begin
            idle_cnt_q <= '0;
            if (hit) begin
              up_rdata_q <= hit_line;
              up_resp_q  <= 1'b1;
              state_q    <= RESP;
            end else begin
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {req_tag, OFFSET_W'(0)};
              state_q        <= RD_MEM;
            end
          end else if (up_write) begin
            idle_cnt_q <= '0;
            if (hit || !full) begin
              up_resp_q <= 1'b1;
              state_q   <= RESP;
            end else begin
              // Buffer full: free the head; the write stays pending and is retried in IDLE.
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {head_tag, OFFSET_W'(0)};
              pmem_wdata_q   <= head_line;
              state_q        <= DRAIN;
            end
          end else if (idle_cnt_q != IC_W'(DRAIN_DELAY)) begin
            idle_cnt_q <= idle_cnt_q + IC_W'(1);
          end else if (!empty) begin
            pmem_write_q   <= 1'b1;
            pmem_address_q <= {head_tag, OFFSET_W'(0)};
            pmem_wdata_q   <= head_line;
            state_q        <= DRAIN;
          end
        end
        RD_MEM: begin
          if (pmem_resp) begin
            up_rdata_q     <= pmem_rdata;
            up_resp_q      <= 1'b1;
            pmem_read_q    <= 1'b0;
            pmem_address_q <= '0;
            state_q        <= RESP;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            state_q        <= IDLE;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign up_resp      = up_resp_q;
  assign up_rdata     = up_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign wb_empty     = empty;

endmodule

// File: tb/tb_l2_wb_scheduler.sv
// Scoreboard bench for l2_wb_scheduler: directed requests push expected events,
// a negedge monitor pops and compares every up_resp and pmem request it observes.
module tb_l2_wb_scheduler;

  localparam int K_UP = 0;
  localparam int K_RD = 1;
  localparam int K_WR = 2;
  localparam int MEM_LAT = 2;

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [255:0] data;
    bit           chk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         up_read = 1'b0;
  logic         up_write = 1'b0;
  logic [31:0]  up_addr = '0;
  logic [255:0] up_wdata = '0;
  logic         up_resp;
  logic [255:0] up_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [255:0] pmem_rdata = '0;
  logic         wb_empty;

  int   vectors = 0;
  int   errors = 0;
  int   pmem_act = 0;
  int   act_before;
  bit   hold_resp = 1'b0;
  exp_t exp_q[$];

  l2_wb_scheduler #(.DEPTH(2), .DRAIN_DELAY(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up_read      (up_read),
    .up_write     (up_write),
    .up_addr      (up_addr),
    .up_wdata     (up_wdata),
    .up_resp      (up_resp),
    .up_rdata     (up_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .wb_empty     (wb_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rd_pat(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  function automatic void expect_ev(input int kind, input logic [31:0] addr,
                                    input logic [255:0] data, input bit chk);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.chk  = chk;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] addr, input logic [255:0] data);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr %0h, expected no event", kind, addr);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || (kind != K_UP && e.addr !== addr) || (e.chk && e.data !== data)) begin
      errors++;
      $display("FAIL event: got kind %0d addr %0h data %0h, expected kind %0d addr %0h data %0h",
               kind, addr, data, e.kind, e.addr, e.data);
    end
  endtask

  // Monitor: compares every observed DUT output event against the scoreboard queue.
  initial begin
    logic prev_rd, prev_wr;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (pmem_read && pmem_write) begin
        vectors++;
        errors++;
        $display("FAIL rd_wr_exclusive: got both 1, expected at most one");
      end
      if (pmem_read && !prev_rd) begin
        pmem_act++;
        observe(K_RD, pmem_address, '0);
      end
      if (pmem_write && !prev_wr) begin
        pmem_act++;
        observe(K_WR, pmem_address, pmem_wdata);
      end
      if (up_resp) observe(K_UP, '0, up_rdata);
      prev_rd = pmem_read;
      prev_wr = pmem_write;
    end
  end

  // Memory model: completes any pmem request MEM_LAT+1 cycles after it is seen.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !hold_resp) begin
        if (lat == MEM_LAT) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rd_pat(pmem_address);
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic up_req(input bit is_wr, input logic [31:0] addr, input logic [255:0] data,
                        input bit chk_lat, input string name);
    int n;
    @(posedge clk);
    #1;
    up_write = is_wr;
    up_read  = !is_wr;
    up_addr  = addr;
    up_wdata = data;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (up_resp) break;
      if (n > 200) begin
        vectors++;
        errors++;
        $display("FAIL %s_timeout: got no up_resp in %0d cycles, expected one", name, n);
        break;
      end
    end
    if (chk_lat) check({name, "_latency"}, 256'(n), 256'(2));
    @(posedge clk);
    #1;
    up_write = 1'b0;
    up_read  = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (!(wb_empty && !pmem_write && !pmem_read && exp_q.size() == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wb_empty"}, 256'(wb_empty), 256'(1));
    check({name, "_sb_empty"}, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic reset_checks(input string name);
    check({name, "_up_resp"}, 256'(up_resp), 256'(0));
    check({name, "_up_rdata"}, up_rdata, '0);
    check({name, "_pmem_read"}, 256'(pmem_read), 256'(0));
    check({name, "_pmem_write"}, 256'(pmem_write), 256'(0));
    check({name, "_pmem_addr"}, 256'(pmem_address), 256'(0));
    check({name, "_pmem_wdata"}, pmem_wdata, '0);
    check({name, "_wb_empty"}, 256'(wb_empty), 256'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d1, d2, d3;
    logic [31:0]  a, b, c;
    int n;
    d1 = {8{32'hD1D1_0001}};
    d2 = {8{32'hD2D2_0002}};
    d3 = {8{32'hD3D3_0003}};

    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;

    // 1: mid-sim reset while up_resp is high, buffered line discarded
    expect_ev(K_UP, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    up_write = 1'b1;
    up_addr  = 32'h0600_0000;
    up_wdata = d3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!up_resp && n < 50);
    check("t1_up_resp_seen", 256'(up_resp), 256'(1));
    check("t1_wb_nonempty", 256'(wb_empty), 256'(0));
    #2 rst_n = 1'b0;
    #1 reset_checks("t1_rst");
    up_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    act_before = pmem_act;
    repeat (20) @(negedge clk);
    check("t1_no_pmem", 256'(pmem_act - act_before), 256'(0));
    check("t1_wb_empty", 256'(wb_empty), 256'(1));

    // 2: write accepted then opportunistically drained
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_WR, 32'h1000_0040, d1, 1'b1);
    up_req(1'b1, 32'h1000_0040, d1, 1'b1, "t2_wr");
    check("t2_wb_nonempty", 256'(wb_empty), 256'(0));
    wait_quiet("t2");

    // 3: read hit forwarded from buffer, no pmem_read
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_UP, '0, d1, 1'b1);
    expect_ev(K_WR, 32'h2000_0000, d1, 1'b1);
    up_req(1'b1, 32'h2000_0000, d1, 1'b1, "t3_wr");
    up_req(1'b0, 32'h2000_001C, '0, 1'b1, "t3_rd_hit");
    wait_quiet("t3");

    // 4: third write to a full buffer forces a drain of the oldest entry
    a = 32'h4000_0000;
    b = 32'h4000_0020;
    c = 32'h4000_0040;
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_WR, a, d1, 1'b1);
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_UP, '0, d2, 1'b1);
    expect_ev(K_UP, '0, d3, 1'b1);
    expect_ev(K_RD, a, '0, 1'b0);
    expect_ev(K_UP, '0, rd_pat(a), 1'b1);
    expect_ev(K_WR, b, d2, 1'b1);
    expect_ev(K_WR, c, d3, 1'b1);
    up_req(1'b1, a, d1, 1'b1, "t4_wr_a");
    up_req(1'b1, b, d2, 1'b1, "t4_wr_b");
    up_req(1'b1, c, d3, 1'b0, "t4_wr_c");
    up_req(1'b0, b, '0, 1'b1, "t4_rd_b");
    up_req(1'b0, c + 32'h4, '0, 1'b1, "t4_rd_c");
    up_req(1'b0, a + 32'h4, '0, 1'b0, "t4_rd_a");
    wait_quiet("t4");

    // 5: coalesced writes, then a read miss bypasses the queued write
    a = 32'h6000_0000;
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_RD, 32'h3000_0000, '0, 1'b0);
    expect_ev(K_UP, '0, rd_pat(32'h3000_0000), 1'b1);
    expect_ev(K_WR, a, d2, 1'b1);
    up_req(1'b1, a, d1, 1'b1, "t5_wr1");
    up_req(1'b1, a, d2, 1'b1, "t5_wr2");
    up_req(1'b0, 32'h3000_0000, '0, 1'b0, "t5_rd_miss");
    wait_quiet("t5");

    // 6: reset while a drain is outstanding abandons it without retry
    expect_ev(K_UP, '0, '0, 1'b0);
    expect_ev(K_WR, 32'h5000_0000, d1, 1'b1);
    hold_resp = 1'b1;
    up_req(1'b1, 32'h5000_0000, d1, 1'b1, "t6_wr");
    n = 0;
    while (!pmem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_drain_started", 256'(pmem_write), 256'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("t6_rst");
    hold_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    act_before = pmem_act;
    repeat (20) @(negedge clk);
    check("t6_no_retry", 256'(pmem_act - act_before), 256'(0));
    check("t6_wb_empty", 256'(wb_empty), 256'(1));
    check("t6_sb_empty", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
